// File: rtl/iq_pkg.sv
// Shared types and helpers for the instruction queue: entry record, per-lane decode
// record and RV32 immediate extraction.
package iq_pkg;

  localparam int unsigned ISSUE_W_MAX = 2;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instr;
  } iq_entry_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } iq_dec_t;

  function automatic logic [31:0] decode_imm(input logic [31:0] w);
    logic [31:0] imm;
    case (w[6:0])
      OpLoad, OpImm, OpJalr: imm = {{20{w[31]}}, w[31:20]};
      OpStore:               imm = {{20{w[31]}}, w[31:25], w[11:7]};
      OpBranch:              imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      OpLui, OpAuipc:        imm = {w[31:12], 12'b0};
      OpJal:                 imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:               imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/iq_decode_lane.sv
// Field decode for one issue lane: register indices, function codes and immediate.
module iq_decode_lane
  import iq_pkg::*;
(
  input  logic [31:0] instr_i,
  output iq_dec_t     dec_o
);

  always_comb begin
    dec_o.opcode = instr_i[6:0];
    dec_o.rd     = instr_i[11:7];
    dec_o.funct3 = instr_i[14:12];
    dec_o.rs1    = instr_i[19:15];
    dec_o.rs2    = instr_i[24:20];
    dec_o.funct7 = instr_i[31:25];
    dec_o.imm    = decode_imm(instr_i);
  end

endmodule

// File: rtl/instr_queue_sx.sv
// In-order instruction queue: entries allocated at fetch, filled in order by imem
// responses, issued up to ISSUE_W per cycle. Define IQ_BYPASS_EN to forward a head fill.
module instr_queue_sx
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH_BITS   = 4,
  parameter int unsigned ISSUE_W      = 2,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  input  logic [63:0]             alloc_order,
  input  logic [31:0]             alloc_pc,
  input  logic [31:0]             alloc_pc_next,
  input  logic                    resp_valid,
  input  logic [31:0]             resp_rdata,
  output logic [ISSUE_W-1:0]      issue_valid,
  input  logic [ISSUE_W-1:0]      issue_pop,
  output logic [ISSUE_W*64-1:0]   issue_order,
  output logic [ISSUE_W*32-1:0]   issue_instr,
  output logic [ISSUE_W*32-1:0]   issue_pc,
  output logic [ISSUE_W*32-1:0]   issue_pc_next,
  output iq_dec_t [ISSUE_W-1:0]   issue_dec,
  output logic [DEPTH_BITS:0]     count,
  output logic [DEPTH_BITS:0]     pending,
  output logic                    almost_full
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam int unsigned CW    = DEPTH_BITS + 1;

  typedef logic [DEPTH_BITS-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;
  typedef logic [CW:0]           wide_t;

  iq_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  ptr_t             alloc_ptr_q, alloc_ptr_d, fill_ptr_q, fill_ptr_d, head_ptr_q, head_ptr_d;
  cnt_t             count_q, count_d, pending_q, pending_d, discard_q, discard_d;

  logic             alloc_fire, resp_fill, resp_drop, bypass;
  cnt_t             pop_k;
  wide_t            disc_sum;
  ptr_t             idx;
  logic             prev_ok;
  logic [ISSUE_W-1:0] pop_inc;

  assign alloc_ready = count_q < cnt_t'(DEPTH);
  assign almost_full = (cnt_t'(DEPTH) - count_q) <= cnt_t'(AFULL_MARGIN);
  assign count       = count_q;
  assign pending     = pending_q;

  assign alloc_fire = alloc_valid && alloc_ready && !flush;
  assign resp_drop  = resp_valid && !flush && (discard_q != '0);
  assign resp_fill  = resp_valid && !flush && (discard_q == '0) && (pending_q != '0);

`ifdef IQ_BYPASS_EN
  assign bypass = resp_fill && (count_q != '0) && (fill_ptr_q == head_ptr_q);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    pop_k = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      pop_k = pop_k + cnt_t'(issue_pop[i]);
    end
  end

  // Lane i is valid only if every older lane is valid, keeping issue strictly in order.
  always_comb begin
    issue_valid   = '0;
    issue_order   = '0;
    issue_instr   = '0;
    issue_pc      = '0;
    issue_pc_next = '0;
    idx           = head_ptr_q;
    prev_ok       = 1'b1;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      idx = head_ptr_q + ptr_t'(i);
      issue_valid[i] = prev_ok && (((count_q > cnt_t'(i)) && filled_q[idx]) ||
                                   ((i == 0) && bypass));
      prev_ok = issue_valid[i];
      issue_order[i*64 +: 64]   = mem_q[idx].order;
      issue_pc[i*32 +: 32]      = mem_q[idx].pc;
      issue_pc_next[i*32 +: 32] = mem_q[idx].pc_next;
      issue_instr[i*32 +: 32]   = ((i == 0) && bypass) ? resp_rdata : mem_q[idx].instr;
    end
  end

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
    pending_d   = pending_q;
    discard_d   = discard_q;
    filled_d    = filled_q;
    disc_sum    = '0;
    if (flush) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      count_d     = '0;
      pending_d   = '0;
      filled_d    = '0;
      // Every unfilled entry still has a response in flight; a response this cycle is one of them.
      disc_sum = {1'b0, discard_q} + {1'b0, pending_q};
      if (resp_valid && (disc_sum != '0)) disc_sum = disc_sum - wide_t'(1);
      discard_d = disc_sum[CW] ? '1 : disc_sum[CW-1:0];
    end else begin
      if (alloc_fire) begin
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d = alloc_ptr_q + ptr_t'(1);
      end
      if (resp_fill) begin
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d = fill_ptr_q + ptr_t'(1);
      end
      head_ptr_d = head_ptr_q + ptr_t'(pop_k);
      count_d    = count_q + cnt_t'(alloc_fire) - pop_k;
      pending_d  = pending_q + cnt_t'(alloc_fire) - cnt_t'(resp_fill);
      discard_d  = discard_q - cnt_t'(resp_drop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      pending_q   <= '0;
      discard_q   <= '0;
      filled_q    <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      discard_q   <= discard_d;
      filled_q    <= filled_d;
    end
  end

  // Entry payload carries no reset; the filled bits alone qualify it.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      mem_q[alloc_ptr_q].order   <= alloc_order;
      mem_q[alloc_ptr_q].pc      <= alloc_pc;
      mem_q[alloc_ptr_q].pc_next <= alloc_pc_next;
    end
    if (resp_fill) begin
      mem_q[fill_ptr_q].instr <= resp_rdata;
    end
  end

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
    iq_decode_lane u_dec (
      .instr_i (issue_instr[g*32 +: 32]),
      .dec_o   (issue_dec[g])
    );
  end

  assign pop_inc = issue_pop + ISSUE_W'(1);

  a_lanes: assert property (@(posedge clk) (ISSUE_W >= 1) && (ISSUE_W <= ISSUE_W_MAX))
    else $warning("iq: ISSUE_W out of range");
  a_alloc: assert property (@(posedge clk) disable iff (rst) alloc_valid |-> alloc_ready)
    else $warning("iq: alloc while full ignored");
  a_resp: assert property (@(posedge clk) disable iff (rst)
                           (resp_valid && !flush) |-> ((discard_q != '0) || (pending_q != '0)))
    else $warning("iq: unexpected imem response ignored");
  a_pop: assert property (@(posedge clk) disable iff (rst)
                          !flush |-> (((issue_pop & ~issue_valid) == '0) &&
                                      ((pop_inc & issue_pop) == '0)))
    else $warning("iq: illegal pop pattern");

endmodule
